// File: rtl/memory_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word access to an internal data memory
// and the M/W pipeline register feeding write-back.
module memory_access_stage #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUout,
  input  logic [31:0] XM_B,
  input  logic [4:0]  XM_RD,
  input  logic        XM_lwFlag,
  input  logic        XM_swFlag,
  input  logic        stall,
  output logic [31:0] MW_data,
  output logic [4:0]  MW_RD,
  output logic        MW_regWrite,
  output logic        MW_memToReg,
  output logic        MW_misalign
);

  typedef enum logic [1:0] {
    OP_ALU = 2'd0,
    OP_LW  = 2'd1,
    OP_SW  = 2'd2
  } op_e;

  logic [31:0]       mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] idx_s;
  logic              aligned_s;
  logic              mem_we_s;
  op_e               op_s;

  logic [31:0] mw_data_q, mw_data_d;
  logic [4:0]  mw_rd_q, mw_rd_d;
  logic        mw_regwrite_q, mw_regwrite_d;
  logic        mw_memtoreg_q, mw_memtoreg_d;
  logic        mw_misalign_q, mw_misalign_d;

  // Address bits above the word index alias and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, ALUout[31:ADDR_W+2]};

  assign idx_s     = ALUout[ADDR_W+1:2];
  assign aligned_s = (ALUout[1:0] == 2'b00);

  // Decode the operation; lw wins when both flags are set.
  always_comb begin
    op_s = OP_ALU;
    if (XM_lwFlag) begin
      op_s = OP_LW;
    end else if (XM_swFlag) begin
      op_s = OP_SW;
    end else begin
      op_s = OP_ALU;
    end
  end

  assign mem_we_s = (op_s == OP_SW) && aligned_s && !stall && !rst;

  // Data memory array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= XM_B;
    end
  end

  // Next M/W register value; stall holds everything.
  always_comb begin
    mw_data_d     = mw_data_q;
    mw_rd_d       = mw_rd_q;
    mw_regwrite_d = mw_regwrite_q;
    mw_memtoreg_d = mw_memtoreg_q;
    mw_misalign_d = mw_misalign_q;
    if (!stall) begin
      case (op_s)
        OP_ALU: begin
          mw_data_d     = ALUout;
          mw_rd_d       = XM_RD;
          mw_regwrite_d = (XM_RD != 5'd0);
          mw_memtoreg_d = 1'b0;
          mw_misalign_d = 1'b0;
        end
        OP_LW: begin
          if (aligned_s) begin
            mw_data_d     = mem_q[idx_s];
            mw_rd_d       = XM_RD;
            mw_regwrite_d = (XM_RD != 5'd0);
            mw_memtoreg_d = 1'b1;
            mw_misalign_d = 1'b0;
          end else begin
            mw_data_d     = 32'd0;
            mw_rd_d       = 5'd0;
            mw_regwrite_d = 1'b0;
            mw_memtoreg_d = 1'b0;
            mw_misalign_d = 1'b1;
          end
        end
        OP_SW: begin
          mw_data_d     = 32'd0;
          mw_rd_d       = 5'd0;
          mw_regwrite_d = 1'b0;
          mw_memtoreg_d = 1'b0;
          mw_misalign_d = !aligned_s;
        end
        default: begin
          mw_data_d     = 32'd0;
          mw_rd_d       = 5'd0;
          mw_regwrite_d = 1'b0;
          mw_memtoreg_d = 1'b0;
          mw_misalign_d = 1'b0;
        end
      endcase
    end else begin
      mw_data_d     = mw_data_q;
      mw_rd_d       = mw_rd_q;
      mw_regwrite_d = mw_regwrite_q;
      mw_memtoreg_d = mw_memtoreg_q;
      mw_misalign_d = mw_misalign_q;
    end
  end

  // M/W pipeline register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mw_data_q     <= 32'd0;
      mw_rd_q       <= 5'd0;
      mw_regwrite_q <= 1'b0;
      mw_memtoreg_q <= 1'b0;
      mw_misalign_q <= 1'b0;
    end else begin
      mw_data_q     <= mw_data_d;
      mw_rd_q       <= mw_rd_d;
      mw_regwrite_q <= mw_regwrite_d;
      mw_memtoreg_q <= mw_memtoreg_d;
      mw_misalign_q <= mw_misalign_d;
    end
  end

  assign MW_data     = mw_data_q;
  assign MW_RD       = mw_rd_q;
  assign MW_regWrite = mw_regwrite_q;
  assign MW_memToReg = mw_memtoreg_q;
  assign MW_misalign = mw_misalign_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios plus random
// traffic compared against a word-array reference model.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUout, XM_B;
  logic [4:0]  XM_RD;
  logic        XM_lwFlag, XM_swFlag, stall;
  logic [31:0] MW_data;
  logic [4:0]  MW_RD;
  logic        MW_regWrite, MW_memToReg, MW_misalign;

  memory_access_stage #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .ALUout(ALUout), .XM_B(XM_B), .XM_RD(XM_RD),
    .XM_lwFlag(XM_lwFlag), .XM_swFlag(XM_swFlag), .stall(stall),
    .MW_data(MW_data), .MW_RD(MW_RD), .MW_regWrite(MW_regWrite),
    .MW_memToReg(MW_memToReg), .MW_misalign(MW_misalign)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] ref_mem [256];
  logic [31:0] exp_data;
  logic [4:0]  exp_rd;
  logic        exp_rw, exp_m2r, exp_mis;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check_val({tag, ".data"},  MW_data, exp_data);
    check_val({tag, ".rd"},    {27'd0, MW_RD}, {27'd0, exp_rd});
    check_val({tag, ".rw"},    {31'd0, MW_regWrite}, {31'd0, exp_rw});
    check_val({tag, ".m2r"},   {31'd0, MW_memToReg}, {31'd0, exp_m2r});
    check_val({tag, ".mis"},   {31'd0, MW_misalign}, {31'd0, exp_mis});
  endtask

  task automatic model_reset();
    exp_data = 32'd0; exp_rd = 5'd0; exp_rw = 1'b0; exp_m2r = 1'b0; exp_mis = 1'b0;
  endtask

  // One pipeline cycle: drive, clock, advance model, compare.
  task automatic do_cycle(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic lw, input logic sw, input logic st);
    int  idx;
    bit  al;
    ALUout = a; XM_B = b; XM_RD = rd; XM_lwFlag = lw; XM_swFlag = sw; stall = st;
    @(posedge clk);
    idx = int'((a >> 2) % 256);
    al  = (a % 4) == 0;
    if (!st) begin
      if (lw) begin
        if (al) begin
          exp_data = ref_mem[idx]; exp_rd = rd; exp_rw = (rd != 0); exp_m2r = 1'b1; exp_mis = 1'b0;
        end else begin
          model_reset(); exp_mis = 1'b1;
        end
      end else if (sw) begin
        model_reset(); exp_mis = !al;
        if (al) ref_mem[idx] = b;
      end else begin
        exp_data = a; exp_rd = rd; exp_rw = (rd != 0); exp_m2r = 1'b0; exp_mis = 1'b0;
      end
    end
    #1;
    check_outs(tag);
  endtask

  initial begin
    rst = 1'b1; ALUout = 32'd0; XM_B = 32'd0; XM_RD = 5'd0;
    XM_lwFlag = 1'b0; XM_swFlag = 1'b0; stall = 1'b0;
    model_reset();
    #12;
    check_outs("rst_init");
    rst = 1'b0;

    // Fill memory with known values avoiding 32'h77.
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom | 32'h0001_0000;
      do_cycle("fill", i * 4, v, 5'd0, 1'b0, 1'b1, 1'b0);
    end

    // Async reset with all inputs nonzero, store in reset cycle suppressed
    do_cycle("alu_pre", 32'h0000_1234, 32'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    ALUout = 32'h0000_0040; XM_B = 32'hAAAA_5555; XM_RD = 5'd7;
    XM_lwFlag = 1'b0; XM_swFlag = 1'b1; stall = 1'b1;
    #2 rst = 1'b1;
    #1 model_reset();
    check_outs("rst_async");
    stall = 1'b0;
    @(posedge clk); #1;
    check_outs("rst_hold");
    @(negedge clk); rst = 1'b0;
    do_cycle("rst_nowrite", 32'h0000_0040, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0);

    // ALU pass-through
    do_cycle("alu", 32'h0000_1234, 32'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    check_val("alu_const", MW_data, 32'h0000_1234);
    // Store then load
    do_cycle("sw10", 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0);
    do_cycle("lw10", 32'h10, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    check_val("lw10_const", MW_data, 32'hDEAD_BEEF);
    // Aliasing
    do_cycle("sw_alias", 32'h0000_0404, 32'h55, 5'd0, 1'b0, 1'b1, 1'b0);
    do_cycle("lw_alias", 32'h4, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    check_val("alias_const", MW_data, 32'h55);
    // Misaligned sw and lw
    do_cycle("sw_mis", 32'h13, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1, 1'b0);
    do_cycle("lw_after_mis", 32'h10, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    check_val("nowrite_const", MW_data, 32'hDEAD_BEEF);
    do_cycle("lw_mis", 32'h11, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    // Stall holds outputs and suppresses store
    do_cycle("alu_st", 32'h0000_1234, 32'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    do_cycle("stall_sw", 32'h20, 32'h77, 5'd0, 1'b0, 1'b1, 1'b1);
    check_val("stall_const", MW_data, 32'h0000_1234);
    do_cycle("lw20", 32'h20, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    // Both flags: behaves as lw
    do_cycle("both", 32'h10, 32'h1111_2222, 5'd4, 1'b1, 1'b1, 1'b0);
    do_cycle("both_chk", 32'h10, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    // Load into r0
    do_cycle("lw_r0", 32'h10, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);

    // Random traffic over a small aliased window
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      int          k;
      logic        lw, sw;
      k  = $urandom_range(0, 9);
      lw = (k < 4) || (k == 9);
      sw = (k >= 4 && k < 7) || (k == 9);
      a  = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'd0,
            8'($urandom_range(0, 15)),
            $urandom_range(0, 4) == 0 ? 2'($urandom) : 2'b00};
      do_cycle("rand", a, $urandom, 5'($urandom), lw, sw, $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
